// File: rtl/multalu_pipe_if.sv
// Operand, control and result bundle for one multalu_pipe instance.
// The master drives operands and the cascade input; the slave is the ALU.
interface multalu_pipe_if #(
  parameter int unsigned A_WIDTH   = 18,
  parameter int unsigned B_WIDTH   = 36,
  parameter int unsigned C_WIDTH   = 54,
  parameter int unsigned ACC_WIDTH = 55,
  parameter int unsigned OUT_WIDTH = 64
);
  logic                 in_valid;
  logic [A_WIDTH-1:0]   a;
  logic [B_WIDTH-1:0]   b;
  logic [C_WIDTH-1:0]   c;
  logic                 asign;
  logic                 bsign;
  logic [1:0]           mode;
  logic                 sub;
  logic                 accload;
  logic [ACC_WIDTH-1:0] casi;
  logic [ACC_WIDTH-1:0] caso;
  logic [OUT_WIDTH-1:0] dout;
  logic                 out_valid;

  modport master (
    output in_valid, a, b, c, asign, bsign, mode, sub, accload, casi,
    input  caso, dout, out_valid
  );

  modport slave (
    input  in_valid, a, b, c, asign, bsign, mode, sub, accload, casi,
    output caso, dout, out_valid
  );
endinterface

// File: rtl/multalu_pipe.sv
// Pipelined multiply-ALU: optional input and post-multiplier registers, then an
// accumulate stage selecting P±C, accumulate, cascade-add or plain product.
module multalu_pipe #(
  parameter int unsigned A_WIDTH   = 18,
  parameter int unsigned B_WIDTH   = 36,
  parameter int unsigned C_WIDTH   = 54,
  parameter int unsigned ACC_WIDTH = 55,
  parameter int unsigned OUT_WIDTH = 64,
  parameter int unsigned IN_REG    = 1,
  parameter int unsigned PIPE_REG  = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ce,
  multalu_pipe_if.slave  bus
);
  localparam int unsigned P_WIDTH = A_WIDTH + B_WIDTH;

  typedef struct packed {
    logic               valid;
    logic               asign;
    logic               bsign;
    logic [1:0]         mode;
    logic               sub;
    logic               accload;
    logic [C_WIDTH-1:0] c;
  } ctrl_t;

  ctrl_t                w_in_ctrl;
  ctrl_t                w_s1_ctrl;
  logic [A_WIDTH-1:0]   w_s1_a;
  logic [B_WIDTH-1:0]   w_s1_b;
  ctrl_t                w_s2_ctrl;
  logic [P_WIDTH-1:0]   w_s2_p;

  logic [P_WIDTH-1:0]   w_a_ext;
  logic [P_WIDTH-1:0]   w_b_ext;
  logic [P_WIDTH-1:0]   w_p;
  logic [ACC_WIDTH-1:0] w_p_ext;
  logic [ACC_WIDTH-1:0] w_c_ext;
  logic [ACC_WIDTH-1:0] w_r;
  logic [OUT_WIDTH-1:0] w_dout;

  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_sign;
  logic                 r_out_valid;

  assign w_in_ctrl = '{valid:   bus.in_valid,
                       asign:   bus.asign,
                       bsign:   bus.bsign,
                       mode:    bus.mode,
                       sub:     bus.sub,
                       accload: bus.accload,
                       c:       bus.c};

  generate
    if (IN_REG != 0) begin : g_in_reg
      ctrl_t              r_ctrl;
      logic [A_WIDTH-1:0] r_a;
      logic [B_WIDTH-1:0] r_b;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_ctrl <= '0;
          r_a    <= '0;
          r_b    <= '0;
        end else if (ce) begin
          r_ctrl <= w_in_ctrl;
          r_a    <= bus.a;
          r_b    <= bus.b;
        end
      end

      assign w_s1_ctrl = r_ctrl;
      assign w_s1_a    = r_a;
      assign w_s1_b    = r_b;
    end else begin : g_in_bypass
      assign w_s1_ctrl = w_in_ctrl;
      assign w_s1_a    = bus.a;
      assign w_s1_b    = bus.b;
    end
  endgenerate

  // Operands are extended to the full product width so that the low P_WIDTH
  // bits of one unsigned multiply are correct for every sign combination.
  always_comb begin
    w_a_ext = w_s1_ctrl.asign ? P_WIDTH'($signed(w_s1_a)) : P_WIDTH'(w_s1_a);
    w_b_ext = w_s1_ctrl.bsign ? P_WIDTH'($signed(w_s1_b)) : P_WIDTH'(w_s1_b);
    w_p     = w_a_ext * w_b_ext;
  end

  generate
    if (PIPE_REG != 0) begin : g_pipe_reg
      ctrl_t              r_ctrl;
      logic [P_WIDTH-1:0] r_p;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_ctrl <= '0;
          r_p    <= '0;
        end else if (ce) begin
          r_ctrl <= w_s1_ctrl;
          r_p    <= w_p;
        end
      end

      assign w_s2_ctrl = r_ctrl;
      assign w_s2_p    = r_p;
    end else begin : g_pipe_bypass
      assign w_s2_ctrl = w_s1_ctrl;
      assign w_s2_p    = w_p;
    end
  endgenerate

  always_comb begin
    if (w_s2_ctrl.asign | w_s2_ctrl.bsign) begin
      w_p_ext = ACC_WIDTH'($signed(w_s2_p));
    end else begin
      w_p_ext = ACC_WIDTH'(w_s2_p);
    end
    w_c_ext = ACC_WIDTH'($signed(w_s2_ctrl.c));

    w_r = w_p_ext;
    unique case (w_s2_ctrl.mode)
      2'd0: w_r = w_s2_ctrl.sub ? (w_p_ext - w_c_ext) : (w_p_ext + w_c_ext);
      2'd1: w_r = (w_s2_ctrl.accload ? r_acc : w_c_ext)
                + (w_s2_ctrl.sub ? (-w_p_ext) : w_p_ext);
      2'd2: w_r = w_s2_ctrl.sub ? (bus.casi - w_p_ext) : (bus.casi + w_p_ext);
      default: w_r = w_p_ext;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc       <= '0;
      r_sign      <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (ce) begin
      r_out_valid <= w_s2_ctrl.valid;
      if (w_s2_ctrl.valid) begin
        r_acc  <= w_r;
        r_sign <= w_s2_ctrl.asign | w_s2_ctrl.bsign;
      end
    end
  end

  always_comb begin
    if (r_sign) begin
      w_dout = OUT_WIDTH'($signed(r_acc));
    end else begin
      w_dout = OUT_WIDTH'(r_acc);
    end
  end

  assign bus.caso      = r_acc;
  assign bus.dout      = w_dout;
  assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_multalu_pipe.sv
// Directed bench for multalu_pipe: vector table on the default pipeline plus
// accumulate, stall, cascade, zero-latency, reset and wrap sequences.
module tb_multalu_pipe;
  logic clk;
  logic reset;
  logic ce;

  int unsigned n_checks;
  int unsigned n_pass;

  multalu_pipe_if bus_m ();
  multalu_pipe_if bus_d ();
  multalu_pipe_if bus_z ();

  multalu_pipe dut (.clk(clk), .reset(reset), .ce(ce), .bus(bus_m.slave));
  multalu_pipe dut_d (.clk(clk), .reset(reset), .ce(ce), .bus(bus_d.slave));
  multalu_pipe #(.IN_REG(0), .PIPE_REG(0)) dut_z (
    .clk(clk), .reset(reset), .ce(ce), .bus(bus_z.slave)
  );

  assign bus_d.casi = bus_m.caso;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [17:0] a;
    logic [35:0] b;
    logic [53:0] c;
    logic [54:0] casi;
    logic        asign;
    logic        bsign;
    logic [1:0]  mode;
    logic        sub;
    logic        accload;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(string name, logic [17:0] a, logic [35:0] b,
                              logic [53:0] c, logic [54:0] casi, logic asign,
                              logic bsign, logic [1:0] mode, logic sub,
                              logic accload, logic [63:0] exp);
    vec_t v;
    v.name = name; v.a = a; v.b = b; v.c = c; v.casi = casi;
    v.asign = asign; v.bsign = bsign; v.mode = mode; v.sub = sub;
    v.accload = accload; v.exp = exp;
    return v;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic drive(output logic iv, input logic v);
    iv = v;
  endtask

  task automatic set_m(logic [17:0] a, logic [35:0] b, logic [53:0] c,
                       logic asign, logic bsign, logic [1:0] mode,
                       logic sub, logic accload);
    bus_m.in_valid = 1'b1;
    bus_m.a = a; bus_m.b = b; bus_m.c = c;
    bus_m.asign = asign; bus_m.bsign = bsign;
    bus_m.mode = mode; bus_m.sub = sub; bus_m.accload = accload;
  endtask

  logic        sv_valid[7];
  logic        sv_load[7];
  logic        ex_ov[7];
  logic [63:0] ex_dout[7];
  logic        seen;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    ce       = 1'b1;
    set_m('0, '0, '0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    bus_m.in_valid = 1'b0;
    bus_m.casi = '0;
    bus_d.in_valid = 1'b0;
    bus_d.a = '0; bus_d.b = '0; bus_d.c = '0;
    bus_d.asign = 1'b0; bus_d.bsign = 1'b0; bus_d.mode = 2'd0;
    bus_d.sub = 1'b0; bus_d.accload = 1'b0;
    bus_z.in_valid = 1'b0;
    bus_z.a = '0; bus_z.b = '0; bus_z.c = '0; bus_z.casi = '0;
    bus_z.asign = 1'b0; bus_z.bsign = 1'b0; bus_z.mode = 2'd0;
    bus_z.sub = 1'b0; bus_z.accload = 1'b0;

    //              name        a         b                c                  casi      as bs mode sub ld exp
    vecs[0] = mk("m0_sub",     18'h00002, 36'h5F76FE56F, 54'h10000,        55'h0,    0, 0, 0, 1, 0, 64'h0BEEDECADE);
    vecs[1] = mk("m3_ss",      18'h3FFFE, 36'hFFFFFFFFD, 54'h0,            55'h0,    1, 1, 3, 0, 0, 64'h6);
    vecs[2] = mk("m3_su",      18'h3FFFE, 36'h000000003, 54'h0,            55'h0,    1, 0, 3, 0, 0, 64'hFFFFFFFFFFFFFFFA);
    vecs[3] = mk("m0_negc",    18'h00003, 36'h000000004, 54'h3FFFFFFFFFFFFF, 55'h0,  0, 0, 0, 0, 0, 64'hB);
    vecs[4] = mk("m0_maxu",    18'h3FFFF, 36'hFFFFFFFFF, 54'h0,            55'h0,    0, 0, 0, 0, 0, 64'h003FFFEFFFFC0001);
    vecs[5] = mk("m2_sub",     18'h00005, 36'h000000006, 54'h0,            55'h100,  0, 0, 2, 1, 0, 64'hE2);
    vecs[6] = mk("m2_wrap",    18'h00001, 36'h000000020, 54'h0,            55'h10,   0, 0, 2, 1, 0, 64'h007FFFFFFFFFFFF0);
    vecs[7] = mk("m1_ldsub",   18'h00002, 36'h000000003, 54'h123,          55'h0,    0, 0, 1, 1, 0, 64'h11D);
    vecs[8] = mk("m0_sa",      18'h3FFFF, 36'h000000005, 54'h10,           55'h0,    1, 0, 0, 0, 0, 64'hB);
    vecs[9] = mk("m3_sb",      18'h00004, 36'hFFFFFFFFF, 54'h0,            55'h0,    0, 1, 3, 0, 0, 64'hFFFFFFFFFFFFFFFC);

    idle(2);
    #3 reset = 1'b0;
    tick();
    check("rst_dout", bus_m.dout, 64'h0);
    check("rst_valid", {63'h0, bus_m.out_valid}, 64'h0);
    check("rst_caso", {9'h0, bus_m.caso}, 64'h0);

    // Table: one isolated transaction each, latency checked on both sides.
    for (int unsigned i = 0; i < 10; i++) begin
      set_m(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].asign, vecs[i].bsign,
            vecs[i].mode, vecs[i].sub, vecs[i].accload);
      bus_m.casi = vecs[i].casi;
      tick();
      bus_m.in_valid = 1'b0;
      tick();
      check({vecs[i].name, "_early"}, {63'h0, bus_m.out_valid}, 64'h0);
      tick();
      check({vecs[i].name, "_valid"}, {63'h0, bus_m.out_valid}, 64'h1);
      check(vecs[i].name, bus_m.dout, vecs[i].exp);
    end
    bus_m.casi = '0;
    idle(3);

    // Accumulate stream with a bubble in slot 4.
    sv_valid = '{1, 1, 1, 1, 0, 1, 1};
    sv_load  = '{0, 1, 1, 1, 1, 1, 1};
    ex_ov    = '{1, 1, 1, 1, 0, 1, 1};
    ex_dout  = '{64'h2000, 64'h4000, 64'h6000, 64'h8000, 64'h8000, 64'hA000, 64'hC000};
    for (int unsigned t = 1; t <= 9; t++) begin
      if (t <= 7) begin
        set_m(18'h01000, 36'h2, '0, 1'b0, 1'b0, 2'd1, 1'b0, sv_load[t-1]);
        drive(bus_m.in_valid, sv_valid[t-1]);
      end else begin
        bus_m.in_valid = 1'b0;
      end
      tick();
      if (t >= 3) begin
        check($sformatf("acc_v%0d", t - 3), {63'h0, bus_m.out_valid}, {63'h0, ex_ov[t-3]});
        check($sformatf("acc_d%0d", t - 3), bus_m.dout, ex_dout[t-3]);
      end
    end
    idle(3);

    // ce stall while the transaction sits in the post-multiplier register.
    set_m(18'h7, 36'h9, '0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
    tick();
    bus_m.in_valid = 1'b0;
    tick();
    ce = 1'b0;
    seen = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      seen = seen | bus_m.out_valid;
    end
    check("stall_quiet", {63'h0, seen}, 64'h0);
    ce = 1'b1;
    tick();
    check("stall_valid", {63'h0, bus_m.out_valid}, 64'h1);
    check("stall_dout", bus_m.dout, 64'd63);
    ce = 1'b0;
    tick();
    check("stall_hold", {63'h0, bus_m.out_valid}, 64'h1);
    ce = 1'b1;
    tick();
    check("stall_drop", {63'h0, bus_m.out_valid}, 64'h0);
    idle(2);

    // Zero-register build: single-cycle latency.
    bus_z.in_valid = 1'b1; bus_z.a = 18'h3; bus_z.b = 36'h5; bus_z.mode = 2'd3;
    tick();
    bus_z.in_valid = 1'b0;
    check("l1_valid", {63'h0, bus_z.out_valid}, 64'h1);
    check("l1_dout", bus_z.dout, 64'd15);
    tick();
    check("l1_drop", {63'h0, bus_z.out_valid}, 64'h0);

    // Cascade: upstream writes P, downstream adds its own product one cycle later.
    for (int unsigned k = 0; k < 2; k++) begin
      set_m(18'h01000, 36'h2, '0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
      tick();
      bus_m.in_valid = 1'b0;
      bus_d.in_valid = 1'b1; bus_d.a = 18'h3FFFE; bus_d.b = 36'hFFFFFFFFD;
      bus_d.asign = 1'b1; bus_d.bsign = 1'b1; bus_d.mode = 2'd2;
      bus_d.sub = (k == 1);
      tick();
      bus_d.in_valid = 1'b0;
      idle(2);
      check(k == 0 ? "casc_add_v" : "casc_sub_v", {63'h0, bus_d.out_valid}, 64'h1);
      check(k == 0 ? "casc_add" : "casc_sub", bus_d.dout, k == 0 ? 64'h2006 : 64'h1FFA);
      idle(2);
    end

    // Asynchronous reset with two transactions still in flight.
    for (int unsigned i = 0; i < 3; i++) begin
      set_m(18'h1, 36'h7, '0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
      tick();
    end
    bus_m.in_valid = 1'b0;
    check("pre_rst_valid", {63'h0, bus_m.out_valid}, 64'h1);
    check("pre_rst_dout", bus_m.dout, 64'h7);
    #2 reset = 1'b1;
    #1;
    check("arst_dout", bus_m.dout, 64'h0);
    check("arst_valid", {63'h0, bus_m.out_valid}, 64'h0);
    check("arst_caso", {9'h0, bus_m.caso}, 64'h0);
    @(posedge clk);
    #3 reset = 1'b0;
    seen = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      tick();
      seen = seen | bus_m.out_valid;
    end
    check("arst_flushed", {63'h0, seen}, 64'h0);
    set_m(18'h1, 36'h5, '0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1);
    tick();
    bus_m.in_valid = 1'b0;
    idle(2);
    check("post_rst_acc", bus_m.dout, 64'h5);
    idle(2);

    // Wrap: load all-ones then add P=1.
    set_m(18'h0, 36'h0, 54'h3FFFFFFFFFFFFF, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0);
    tick();
    set_m(18'h1, 36'h1, '0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1);
    tick();
    bus_m.in_valid = 1'b0;
    tick();
    check("wrap_load", bus_m.dout, 64'h007FFFFFFFFFFFFF);
    tick();
    check("wrap_dout", bus_m.dout, 64'h0);
    check("wrap_valid", {63'h0, bus_m.out_valid}, 64'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
